seg7_scan_4: RTL

- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Contains its own prescaler and 2-bit digit index counter.
- Decodes the index into one-hot active-low anode strobes. Decodes the selected hex nibble into active-low segment lines.
- Sits between the datapath (which supplies a 16-bit value) and the board display pins. A double-buffered value register prevents tearing mid-frame.

---
 rtl/seg7_scan_4.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_4.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A shadow register collects loads, and they become visible only at a frame wrap, so a frame never shows two values.
module seg7_scan_4 #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [19:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, wrap;
  logic [15:0]   active_val;
  logic [3:0]    active_dp;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    code;

  assign active_val = active_q[19:4];
  assign active_dp  = active_q[3:0];
  assign tick       = enable && (presc_q == PMAX);
  assign wrap       = tick && (digit_idx_q == 2'd3);

  always_comb begin
    presc_d      = presc_q;
    digit_idx_d  = digit_idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = wrap;

    if (enable) begin
      if (tick) begin
        presc_d     = '0;
        digit_idx_d = digit_idx_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (load) begin
      shadow_d  = {value, dp_in};
      pending_d = 1'b1;
    end

    // A load coinciding with the wrap bypasses the shadow and goes straight to display.
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = {value, dp_in};
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (digit_idx_q)
      2'd0: nibble = active_val[3:0];
      2'd1: begin
        nibble = active_val[7:4];
        blank  = blank_lz && (active_val[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = active_val[11:8];
        blank  = blank_lz && (active_val[15:8] == 8'h00);
      end
      default: begin
        nibble = active_val[15:12];
        blank  = blank_lz && (active_val[15:12] == 4'h0);
      end
    endcase

    // Patterns are active-high {a,b,c,d,e,f,g}, with a as the MSB.
    code = 7'h00;
    case (nibble)
      4'h0: code = 7'h7E;
      4'h1: code = 7'h30;
      4'h2: code = 7'h6D;
      4'h3: code = 7'h79;
      4'h4: code = 7'h33;
      4'h5: code = 7'h5B;
      4'h6: code = 7'h5F;
      4'h7: code = 7'h70;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h7B;
      4'hA: code = 7'h77;
      4'hB: code = 7'h1F;
      4'hC: code = 7'h4E;
      4'hD: code = 7'h3D;
      4'hE: code = 7'h4F;
      default: code = 7'h47;
    endcase

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (enable) begin
      an_d  = ~(4'b0001 << digit_idx_q);
      seg_d = blank ? 7'h7F
                    : ~{code[0], code[1], code[2], code[3], code[4], code[5], code[6]};
      dp_d  = ~active_dp[digit_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      digit_idx_q  <= 2'd0;
      shadow_q     <= 20'h00000;
      active_q     <= 20'h00000;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule
